// File: rtl/seq_pkg.sv
// seq_pkg: shared types and field positions for the instruction sequencer.
// Instruction word layout (14 bits):
//   [13:12] opcode   [11:10] branch condition   [11] halt select (opcode 11)
//   [7:0]   branch / jump target (masked to the program-counter width)
package seq_pkg;

   localparam int INSTR_W = 14;
   localparam int FLAG_W  = 4;

   // Field bit positions
   localparam int OP_HI        = 13;
   localparam int OP_LO        = 12;
   localparam int COND_HI      = 11;
   localparam int COND_LO      = 10;
   localparam int CTL_HALT_BIT = 11;
   localparam int TGT_HI       = 7;
   localparam int TGT_LO       = 0;

   typedef logic [INSTR_W-1:0] instr_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_BR  = 2'b10,
      OP_CTL = 2'b11
   } opcode_e;

   // Condition codes double as indices into the captured flag vector
   // {overflow, carry, negative, zero}.
   typedef enum logic [1:0] {
      C_Z = 2'b00,
      C_N = 2'b01,
      C_C = 2'b10,
      C_V = 2'b11
   } cond_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FETCH  = 2'b01,
      SETTLE = 2'b10,
      HALT   = 2'b11
   } state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// seq_prog_mem: DEPTH x 14 program buffer, synchronous write, asynchronous read.
module seq_prog_mem
   import seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  instr_t        wr_data,
   input  logic [AW-1:0] rd_addr,
   output instr_t        rd_data
);

   instr_t mem [DEPTH];

   // Write port: one word per enabled clock edge.
   // NOTE: storage has no reset; only entries below the loaded length are
   // ever fetched, so clearing it would cost a reset fan-out for nothing.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: loads a small program, then fetches it and issues
// ALU words to dataPath, resolving branch/jump/halt locally from the flags
// dataPath reports after each ALU op.
// Optional feature macro: SEQ_RETIRE_COUNT_EN adds a saturating 16-bit
// retire_count output (counts instr_valid pulses, cleared by reset and start).
module instruction_sequencer
   import seq_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int PC_W  = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_valid,
   input  instr_t          load_data,
   output logic            load_ready,
   input  logic            start,
   output instr_t          instruction,
   output logic            instr_valid,
   input  logic            flag_zero,
   input  logic            flag_negative,
   input  logic            flag_carry,
   input  logic            flag_overflow,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted
`ifdef SEQ_RETIRE_COUNT_EN
   ,
   output logic [15:0]     retire_count
`endif
);

   // One extra bit so the load pointer and program length can reach DEPTH.
   localparam int LEN_W = PC_W + 1;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [LEN_W-1:0]  ptr_q, ptr_d;
   logic [LEN_W-1:0]  prog_len_q, prog_len_d;
   instr_t            instruction_q, instruction_d;
   logic              instr_valid_q, instr_valid_d;
   logic [FLAG_W-1:0] flag_q, flag_d;
   logic              load_ready_q, load_ready_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;

   instr_t            fetch_word;
   opcode_e           fetch_op;
   cond_e             fetch_cond;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   target;
   logic              fetch_oob;
   logic              load_wr;
   logic              restart;

   seq_prog_mem #(
      .DEPTH (DEPTH),
      .AW    (PC_W)
   ) u_prog_mem (
      .clk     (clk),
      .wr_en   (load_wr),
      .wr_addr (ptr_q[PC_W-1:0]),
      .wr_data (load_data),
      .rd_addr (pc_q),
      .rd_data (fetch_word)
   );

   assign fetch_op   = opcode_e'(fetch_word[OP_HI:OP_LO]);
   assign fetch_cond = cond_e'(fetch_word[COND_HI:COND_LO]);
   assign target     = fetch_word[TGT_LO +: PC_W];
   assign pc_inc     = pc_q + PC_W'(1);
   // Covers running off the end of the loaded program, including the pc+1
   // wrap to 0 being legal only when the buffer is completely full.
   assign fetch_oob  = {1'b0, pc_q} >= prog_len_q;

   // Next-state and next-output computation for load, fetch/issue and halt.
   // NOTE: every signal gets a default before the case so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ptr_d         = ptr_q;
      prog_len_d    = prog_len_q;
      instruction_d = instruction_q;
      instr_valid_d = 1'b0;
      flag_d        = flag_q;
      load_wr       = 1'b0;
      restart       = 1'b0;

      case (state_q)
         IDLE: begin
            if (load_valid && load_ready_q) begin
               load_wr    = 1'b1;
               ptr_d      = ptr_q + LEN_W'(1);
               prog_len_d = ptr_q + LEN_W'(1);
            end
            // A write in the same cycle counts toward the program length.
            if (start) begin
               restart = 1'b1;
               flag_d  = '0;
               pc_d    = '0;
               state_d = (prog_len_d == '0) ? HALT : FETCH;
            end
         end

         FETCH: begin
            if (fetch_oob) begin
               state_d = HALT;
            end else begin
               case (fetch_op)
                  OP_ADD, OP_SUB: begin
                     instruction_d = fetch_word;
                     instr_valid_d = 1'b1;
                     pc_d          = pc_inc;
                     state_d       = SETTLE;
                  end
                  OP_BR: begin
                     pc_d = flag_q[fetch_cond] ? target : pc_inc;
                  end
                  OP_CTL: begin
                     if (fetch_word[CTL_HALT_BIT]) begin
                        state_d = HALT;
                     end else begin
                        pc_d = target;
                     end
                  end
                  default: state_d = HALT;
               endcase
            end
         end

         SETTLE: begin
            // dataPath has registered the result by the end of this cycle.
            flag_d  = {flag_overflow, flag_carry, flag_negative, flag_zero};
            state_d = FETCH;
         end

         HALT: begin
            if (start) begin
               restart = 1'b1;
               flag_d  = '0;
               pc_d    = '0;
               state_d = FETCH;
            end
         end

         default: state_d = IDLE;
      endcase

      // Status outputs are registered from the next state.
      busy_d       = (state_d == FETCH) || (state_d == SETTLE);
      halted_d     = (state_d == HALT);
      load_ready_d = (state_d == IDLE) && (ptr_d < LEN_W'(DEPTH));
   end

   // State and registered outputs; reset aborts any run immediately.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         ptr_q         <= '0;
         prog_len_q    <= '0;
         instruction_q <= '0;
         instr_valid_q <= 1'b0;
         flag_q        <= '0;
         load_ready_q  <= 1'b1;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ptr_q         <= ptr_d;
         prog_len_q    <= prog_len_d;
         instruction_q <= instruction_d;
         instr_valid_q <= instr_valid_d;
         flag_q        <= flag_d;
         load_ready_q  <= load_ready_d;
         busy_q        <= busy_d;
         halted_q      <= halted_d;
      end
   end

   assign instruction = instruction_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign load_ready  = load_ready_q;

`ifdef SEQ_RETIRE_COUNT_EN
   logic [15:0] retire_q, retire_d;

   // Saturating count of issued ALU words since the last start.
   always_comb begin
      retire_d = retire_q;
      if (restart) begin
         retire_d = '0;
      end else if (instr_valid_d && (retire_q != 16'hFFFF)) begin
         retire_d = retire_q + 16'd1;
      end
   end

   // Retire counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_q <= '0;
      end else begin
         retire_q <= retire_d;
      end
   end

   assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: scoreboard bench. A program-level reference model
// walks each loaded program, pushing every expected issue (word and cycle
// offset from start) into a queue; a monitor pops and compares on instr_valid.
// The bench also plays dataPath: its flags are a fixed function of the
// instruction word, or a forced value for directed branch cases.
module tb_instruction_sequencer;

   localparam int DEPTH = 16;

   typedef struct {
      logic [13:0] word;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        load_valid;
   logic [13:0] load_data;
   logic        load_ready;
   logic        start;
   logic [13:0] instruction;
   logic        instr_valid;
   logic        flag_zero, flag_negative, flag_carry, flag_overflow;
   logic [3:0]  pc;
   logic        busy;
   logic        halted;
`ifdef SEQ_RETIRE_COUNT_EN
   logic [15:0] retire_count;
`endif

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          start_edge = 0;

   logic [13:0] prog [DEPTH];
   int          prog_len;
   bit          force_en;
   logic [3:0]  force_val;

   exp_t        exp_q [$];
   int          exp_halt_cyc;
   int          exp_pc;
   int          exp_issues;

   instruction_sequencer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .start         (start),
      .instruction   (instruction),
      .instr_valid   (instr_valid),
      .flag_zero     (flag_zero),
      .flag_negative (flag_negative),
      .flag_carry    (flag_carry),
      .flag_overflow (flag_overflow),
      .pc            (pc),
      .busy          (busy),
      .halted        (halted)
`ifdef SEQ_RETIRE_COUNT_EN
      ,
      .retire_count  (retire_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // dataPath stand-in: flags {V,C,N,Z} as a fixed function of the word.
   function automatic logic [3:0] dp_flags(input logic [13:0] w);
      return w[3:0] ^ w[7:4] ^ w[11:8];
   endfunction

   assign {flag_overflow, flag_carry, flag_negative, flag_zero} =
      force_en ? force_val : dp_flags(instruction);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Reference model: executes the program at instruction level.
   // ALU op costs 2 cycles (issue + settle), branch/jump 1 cycle.
   task automatic model_push(input bit from_idle);
      int          p;
      int          c;
      logic [3:0]  fl;
      logic [13:0] w;
      bit          done;
      p = 0; c = 1; fl = '0; done = 0; exp_issues = 0;
      if (from_idle && prog_len == 0) begin
         exp_halt_cyc = 0;
         exp_pc = 0;
         return;
      end
      for (int step = 0; step < 2000 && !done; step++) begin
         if (p >= prog_len) begin
            done = 1;
         end else begin
            w = prog[p];
            case (w[13:12])
               2'b00, 2'b01: begin
                  exp_q.push_back('{word: w, cyc: c});
                  fl = force_en ? force_val : dp_flags(w);
                  c += 2;
                  p = (p + 1) % DEPTH;
                  exp_issues++;
               end
               2'b10: begin
                  p = fl[w[11:10]] ? int'(w[7:0]) % DEPTH : (p + 1) % DEPTH;
                  c += 1;
               end
               default: begin
                  if (w[11]) done = 1;
                  else begin
                     p = int'(w[7:0]) % DEPTH;
                     c += 1;
                  end
               end
            endcase
         end
      end
      exp_halt_cyc = c;
      exp_pc = p;
   endtask

   // Monitor: every instr_valid pulse must match the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && instr_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_issue", 32'(instruction), 32'h0);
            end else begin
               e = exp_q.pop_front();
               check("issue_word", 32'(instruction), 32'(e.word));
               check("issue_cycle", 32'(cyc - start_edge), 32'(e.cyc));
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1; load_valid = 1'b0; start = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_word(input logic [13:0] w, input bit with_start);
      int n = 0;
      load_valid = 1'b1;
      load_data  = w;
      while (!load_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("load_accepted", 32'(n < 20), 32'd1);
      if (with_start) begin
         start = 1'b1;
         start_edge = cyc + 1;
      end
      @(negedge clk);
      load_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic load_prog(input bit fuse_start);
      for (int i = 0; i < prog_len; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         load_word(prog[i], fuse_start && (i == prog_len - 1));
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      start_edge = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the first negedge after the start edge.
   task automatic wait_check(input string tag, input bit mid_start);
      bit seen = 0;
      int off = -1;
      check({tag, " busy_after_start"}, 32'(busy), 32'(exp_halt_cyc != 0));
      for (int i = 0; i < 600; i++) begin
         if (halted) begin
            seen = 1;
            off = cyc - start_edge;
            break;
         end
         start = mid_start && (i == 2);
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, " halted"}, 32'(seen), 32'd1);
      check({tag, " halt_cycle"}, 32'(off), 32'(exp_halt_cyc));
      check({tag, " final_pc"}, 32'(pc), 32'(exp_pc));
      check({tag, " issues_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, " busy_in_halt"}, 32'(busy), 32'd0);
      exp_q.delete();
`ifdef SEQ_RETIRE_COUNT_EN
      check({tag, " retire_count"}, 32'(retire_count), 32'(exp_issues));
`endif
   endtask

   task automatic gen_prog();
      logic [13:0] w;
      logic [3:0]  t;
      int          k;
      prog_len = $urandom_range(1, 15);
      for (int i = 0; i < DEPTH; i++) prog[i] = '0;
      for (int i = 0; i < prog_len; i++) begin
         k = $urandom_range(0, 9);
         w = 14'($urandom);
         t = 4'($urandom_range(i + 1, 15));   // forward only: always terminates
         if (k < 5) w[13:12] = k[0] ? 2'b01 : 2'b00;
         else if (k < 8) begin w[13:12] = 2'b10; w[3:0] = t; end
         else if (k < 9) begin w[13:11] = 3'b110; w[3:0] = t; end
         else w[13:11] = 3'b111;
         prog[i] = w;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      reset = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
      force_en = 1'b0; force_val = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst instruction", 32'(instruction), 32'd0);
      check("rst instr_valid", 32'(instr_valid), 32'd0);
      check("rst pc", 32'(pc), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst halted", 32'(halted), 32'd0);
      check("rst load_ready", 32'(load_ready), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Two ALU words then halt; a start pulse mid-run must be ignored.
      do_reset();
      prog[0] = 14'b00_1010_1111_0000;
      prog[1] = 14'b00_1010_0000_1111;
      prog[2] = 14'b11_1000_0000_0000;
      prog_len = 3;
      load_prog(0);
      model_push(1);
      pulse_start();
      wait_check("basic", 1);
      check("basic instr_valid_in_halt", 32'(instr_valid), 32'd0);
      check("basic instruction_held", 32'(instruction), 32'(14'b00_1010_0000_1111));

      // Branch on zero, taken and not taken.
      for (int z = 1; z >= 0; z--) begin
         do_reset();
         force_en = 1'b1;
         force_val = {3'b000, z[0]};
         prog[0] = 14'b01_1010_0001_0001;
         prog[1] = 14'b10_0000_0000_0011;
         prog[2] = 14'b00_0000_0000_0000;
         prog[3] = 14'b11_1000_0000_0000;
         prog_len = 4;
         load_prog(0);
         model_push(1);
         pulse_start();
         wait_check(z ? "br_taken" : "br_not_taken", 0);
      end
      force_en = 1'b0;

      // Fill the buffer; a 17th word must be refused.
      do_reset();
      prog[0] = {2'b10, 2'b00, 2'b00, 8'd2};
      prog[1] = {2'b11, 1'b0, 3'b000, 8'd3};
      prog[2] = {3'b111, 11'd0};
      for (int i = 3; i < 15; i++) prog[i] = {2'b00, 12'($urandom)};
      prog[15] = 14'h0001;
      prog_len = 16;
      load_prog(0);
      check("full load_ready", 32'(load_ready), 32'd0);
      load_valid = 1'b1; load_data = 14'h3FFF;
      repeat (3) @(negedge clk);
      load_valid = 1'b0;
      model_push(1);
      pulse_start();
      wait_check("full", 0);

      // Reset during SETTLE aborts the run.
      do_reset();
      for (int i = 0; i < 4; i++) prog[i] = {2'b00, 12'(i * 7 + 1)};
      prog[4] = 14'b11_1000_0000_0000;
      prog_len = 5;
      load_prog(0);
      model_push(1);
      pulse_start();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (instr_valid) begin seen = 1; break; end
         @(negedge clk);
      end
      check("abort first_issue_seen", 32'(seen), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("abort instr_valid", 32'(instr_valid), 32'd0);
      check("abort pc", 32'(pc), 32'd0);
      check("abort load_ready", 32'(load_ready), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("abort idle_after", 32'({busy, halted, load_ready}), 32'b001);

      // No halt word: runs off the end; restart from HALT recounts.
      do_reset();
      prog[0] = 14'b00_0011_0101_0111;
      prog[1] = 14'b01_1100_0010_1001;
      prog_len = 2;
      load_prog(0);
      model_push(1);
      pulse_start();
      wait_check("run_off_end", 0);
      check("halt load_ready", 32'(load_ready), 32'd0);
      load_valid = 1'b1; load_data = 14'h0123;
      repeat (3) @(negedge clk);
      load_valid = 1'b0;
      model_push(0);
      pulse_start();
`ifdef SEQ_RETIRE_COUNT_EN
      check("restart retire_cleared", 32'(retire_count), 32'd0);
`endif
      wait_check("restart", 0);

      // Empty program: start from IDLE halts at once; restart fetches once.
      do_reset();
      prog_len = 0;
      model_push(1);
      pulse_start();
      wait_check("empty_idle", 0);
      model_push(0);
      pulse_start();
      wait_check("empty_halt", 0);

      // Randomized programs, sometimes starting on the last load write,
      // sometimes restarted from HALT.
      for (int r = 0; r < 30; r++) begin
         bit fuse;
         do_reset();
         gen_prog();
         fuse = ($urandom_range(0, 3) == 0);
         if (fuse) begin
            model_push(1);
            load_prog(1);
         end else begin
            load_prog(0);
            model_push(1);
            pulse_start();
         end
         wait_check("rand", 0);
         if ($urandom_range(0, 1) == 1) begin
            model_push(0);
            pulse_start();
            wait_check("rand_restart", 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
